// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_pkg : shared defaults and stage-state helper for pipe_ctrl
// Rev 1.0
// ============================================================================
package pipe_ctrl_pkg;

  localparam int PIPE_STAGES = 4;
  localparam int PIPE_CNT_W  = 32;

  typedef enum logic [1:0] {
    STG_EMPTY   = 2'd0,
    STG_STALLED = 2'd1,
    STG_LEAVING = 2'd2
  } stage_state_e;

  // A valid stage leaves only when done, downstream has room and no hold.
  function automatic stage_state_e stage_state(input logic valid,
                                               input logic done,
                                               input logic rdy_next,
                                               input logic hold);
    if (!valid) begin
      return STG_EMPTY;
    end
    if (done && rdy_next && !hold) begin
      return STG_LEAVING;
    end
    return STG_STALLED;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_if : handshake and status bundle between the core and pipe_ctrl
// Rev 1.0
// ============================================================================
interface pipe_ctrl_if #(
  parameter int STAGES = pipe_ctrl_pkg::PIPE_STAGES,
  parameter int CNT_W  = pipe_ctrl_pkg::PIPE_CNT_W
);

  logic                    in_valid;
  logic                    in_ready;
  logic [STAGES-1:0]       done;
  logic                    hold;
  logic [STAGES-1:0]       flush_mask;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES-1:0]       ready;
  logic                    retire;
  logic                    perf_clr;
  logic [STAGES*CNT_W-1:0] perf_stall;
  logic [CNT_W-1:0]        perf_retire;

  modport master (
    output in_valid, done, hold, flush_mask, perf_clr,
    input  in_ready, stage_valid, ready, retire, perf_stall, perf_retire
  );

  modport slave (
    input  in_valid, done, hold, flush_mask, perf_clr,
    output in_ready, stage_valid, ready, retire, perf_stall, perf_retire
  );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_perf.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_perf : per-stage stall counters and retire counter (PIPE_PERF_EN)
// Rev 1.0
// ============================================================================
module pipe_ctrl_perf
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = PIPE_STAGES,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clr_i,
  input  logic [STAGES-1:0]       valid_i,
  input  logic [STAGES-1:0]       leave_i,
  input  logic                    retire_i,
  output logic [STAGES*CNT_W-1:0] stall_o,
  output logic [CNT_W-1:0]        retire_o
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [STAGES-1:0][CNT_W-1:0] stall_q;
  logic [CNT_W-1:0]             retire_q;

  // Clear has priority over any same-cycle increment; counters wrap freely.
  always_ff @(posedge clk) begin
    if (!resetn || clr_i) begin
      stall_q  <= '0;
      retire_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (valid_i[i] && !leave_i[i]) begin
          stall_q[i] <= stall_q[i] + C_ONE;
        end
      end
      if (retire_i) begin
        retire_q <= retire_q + C_ONE;
      end
    end
  end

  assign stall_o  = stall_q;
  assign retire_o = retire_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_ctrl : generic N-stage valid/ready pipeline controller with flush/hold
//             Optional counters built when PIPE_PERF_EN is defined.
// Rev 1.0
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = PIPE_STAGES,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic       clk,
  input  logic       resetn,
  pipe_ctrl_if.slave bus
);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] w_valid_eff;
  logic [STAGES-1:0] w_ready;
  logic [STAGES-1:0] w_leave;

  // Masking by reset makes ready read !hold and retire read 0 while in reset.
  assign w_valid_eff = resetn ? valid_q : '0;

  // Ready ripples from the retiring stage back towards fetch in one cycle.
  always_comb begin
    logic         rdy_next;
    stage_state_e st;
    w_ready  = '0;
    w_leave  = '0;
    rdy_next = 1'b1;
    st       = STG_EMPTY;
    for (int i = STAGES - 1; i >= 0; i--) begin
      st         = stage_state(w_valid_eff[i], bus.done[i], rdy_next, bus.hold);
      w_ready[i] = !bus.hold && (st != STG_STALLED);
      w_leave[i] = (st == STG_LEAVING);
      rdy_next   = w_ready[i];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic load_src;
    if (i == 0) begin : g_head
      assign load_src = bus.in_valid;
    end else begin : g_body
      assign load_src = w_leave[i-1];
    end
    assign valid_d[i] = bus.flush_mask[i] ? 1'b0
                      : (w_ready[i] ? load_src : valid_q[i]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign bus.stage_valid = valid_q;
  assign bus.ready       = w_ready;
  assign bus.in_ready    = w_ready[0];
  assign bus.retire      = w_leave[STAGES-1];

`ifdef PIPE_PERF_EN
  pipe_ctrl_perf #(
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) u_perf (
    .clk      (clk),
    .resetn   (resetn),
    .clr_i    (bus.perf_clr),
    .valid_i  (w_valid_eff),
    .leave_i  (w_leave),
    .retire_i (w_leave[STAGES-1]),
    .stall_o  (bus.perf_stall),
    .retire_o (bus.perf_retire)
  );
`else
  logic unused_perf_clr;
  assign unused_perf_clr  = bus.perf_clr;
  assign bus.perf_stall   = '0;
  assign bus.perf_retire  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_ctrl : vector table plus tag scoreboard for pipe_ctrl (4 stages)
// Rev 1.0
// ============================================================================
module tb_pipe_ctrl;

  localparam int S = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAGES(S), .CNT_W(W)) bus ();

  pipe_ctrl #(.STAGES(S), .CNT_W(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic       iv;
    logic [3:0] done;
    logic       hold;
    logic [3:0] flush;
    logic [3:0] e_rdy;
    logic       e_ret;
    logic [3:0] e_sv;
    int         kill;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_q[$];
  int   tag_q[S];
  int   next_tag = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic iv, logic [3:0] d, logic h, logic [3:0] f,
                              logic [3:0] rdy, logic ret, logic [3:0] sv, int kill);
    vec_t v;
    v.iv = iv; v.done = d; v.hold = h; v.flush = f;
    v.e_rdy = rdy; v.e_ret = ret; v.e_sv = sv; v.kill = kill;
    return v;
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input vec_t v);
    int in_tag;
    int t;
    bus.in_valid   = v.iv;
    bus.done       = v.done;
    bus.hold       = v.hold;
    bus.flush_mask = v.flush;
    @(negedge clk);
    check("ready", bus.ready, v.e_rdy);
    check("in_ready", bus.in_ready, v.e_rdy[0]);
    check("retire", bus.retire, v.e_ret);
    if (bus.retire) begin
      if (exp_q.size() == 0) begin
        check("retire_unexpected", 1, 0);
      end else begin
        t = exp_q.pop_front();
        check("retire_tag", tag_q[S-1], t);
      end
    end
    in_tag = -1;
    if (v.iv && bus.in_ready) begin
      in_tag = next_tag;
      if (!v.flush[0]) exp_q.push_back(next_tag);
      next_tag++;
    end
    for (int i = S - 1; i > 0; i--) begin
      if (bus.ready[i]) tag_q[i] = tag_q[i-1];
    end
    if (bus.ready[0]) tag_q[0] = in_tag;
    repeat (v.kill) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    check("stage_valid", bus.stage_valid, v.e_sv);
  endtask

  initial begin
    resetn         = 1'b0;
    bus.in_valid   = 1'b0;
    bus.done       = 4'b0000;
    bus.hold       = 1'b1;
    bus.flush_mask = 4'b0000;
    bus.perf_clr   = 1'b0;
    for (int i = 0; i < S; i++) tag_q[i] = -1;

    // Reset behaviour of ready/retire and the registered state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready_hold", bus.ready, 4'b0000);
    @(posedge clk); #1;
    bus.hold = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.ready, 4'b1111);
    check("rst_retire", bus.retire, 1'b0);
    @(posedge clk); #1;
    check("rst_sv", bus.stage_valid, 4'b0000);
    check("rst_perf_retire", bus.perf_retire, 8'd0);
    check("rst_perf_stall", bus.perf_stall, 32'd0);
    resetn = 1'b1;

    // fill
    vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b0011, 0));
    vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b0111, 0));
    vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b1111, 0));
    vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1111, 0));
    // back-pressure for three cycles, then release
    vecs.push_back(mk(1, 4'b0111, 0, 4'b0000, 4'b0000, 0, 4'b1111, 0));
    vecs.push_back(mk(1, 4'b0111, 0, 4'b0000, 4'b0000, 0, 4'b1111, 0));
    vecs.push_back(mk(1, 4'b0111, 0, 4'b0000, 4'b0000, 0, 4'b1111, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1110, 0));
    // make 1010, then squeeze the bubble
    vecs.push_back(mk(0, 4'b1101, 0, 4'b0000, 4'b1101, 1, 4'b1010, 0));
    vecs.push_back(mk(0, 4'b0111, 0, 4'b0000, 4'b0111, 0, 4'b1100, 0));
    vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1001, 0));
    vecs.push_back(mk(1, 4'b0111, 0, 4'b0000, 4'b0111, 0, 4'b1011, 0));
    vecs.push_back(mk(1, 4'b0111, 0, 4'b0000, 4'b0111, 0, 4'b1111, 0));
    // flush the two youngest under back-pressure
    vecs.push_back(mk(1, 4'b0111, 0, 4'b0011, 4'b0000, 0, 4'b1100, 2));
    vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1001, 0));
    vecs.push_back(mk(1, 4'b0111, 0, 4'b0000, 4'b0111, 0, 4'b1011, 0));
    vecs.push_back(mk(1, 4'b0111, 0, 4'b0000, 4'b0111, 0, 4'b1111, 0));
    // flush together with hold, then plain hold
    vecs.push_back(mk(1, 4'b1111, 1, 4'b0011, 4'b0000, 0, 4'b1100, 2));
    vecs.push_back(mk(1, 4'b1111, 1, 4'b0000, 4'b0000, 0, 4'b1100, 0));
    // accepted-but-dropped input on a stage-0 flush, then drain
    vecs.push_back(mk(1, 4'b1111, 0, 4'b0001, 4'b1111, 1, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b0000, 0));

    foreach (vecs[k]) step(vecs[k]);
    check("queue_empty_table", exp_q.size(), 0);

    // Reset mid-run with a full pipe
    step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b0001, 0));
    step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b0011, 0));
    step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b0111, 0));
    step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b1111, 0));
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_ready", bus.ready, 4'b1111);
    check("midrst_retire", bus.retire, 1'b0);
    @(posedge clk); #1;
    check("midrst_sv", bus.stage_valid, 4'b0000);
    exp_q.delete();
    resetn = 1'b1;
    step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b0001, 0));
    step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b0011, 0));
    step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b0111, 0));
    step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 0, 4'b1111, 0));
    step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1111, 0));

`ifdef PIPE_PERF_EN
    begin
      logic [W-1:0] s3;
      logic [W-1:0] s0;
      s3 = bus.perf_stall[3*W +: W];
      s0 = bus.perf_stall[0 +: W];
      repeat (5) step(mk(1, 4'b0111, 0, 4'b0000, 4'b0000, 0, 4'b1111, 0));
      check("perf_stall3", bus.perf_stall[3*W +: W], s3 + 8'd5);
      check("perf_stall0", bus.perf_stall[0 +: W], s0 + 8'd5);
      step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1111, 0));
      bus.perf_clr = 1'b1;
      step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1111, 0));
      bus.perf_clr = 1'b0;
      check("perf_clr_wins", bus.perf_retire, 8'd0);
      repeat (260) step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1111, 0));
      check("perf_retire_wrap", bus.perf_retire, 8'd4);
      bus.perf_clr = 1'b1;
      step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1111, 0));
      bus.perf_clr = 1'b0;
      check("perf_retire_clr", bus.perf_retire, 8'd0);
      check("perf_stall_clr", bus.perf_stall, 32'd0);
    end
`else
    repeat (3) step(mk(1, 4'b0111, 0, 4'b0000, 4'b0000, 0, 4'b1111, 0));
    bus.perf_clr = 1'b1;
    step(mk(1, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1111, 0));
    bus.perf_clr = 1'b0;
    check("perf_stall_tied", bus.perf_stall, 32'd0);
    check("perf_retire_tied", bus.perf_retire, 8'd0);
`endif

    // Drain and confirm every surviving tag retired exactly once
    step(mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1110, 0));
    step(mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1100, 0));
    step(mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b1000, 0));
    step(mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 1, 4'b0000, 0));
    check("queue_empty_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
